// File: rtl/imu_adc_filter_if.sv
// Raw ADC bus in, averaged bus out; slave = filter side, master = producer/consumer side.
// cal_strobe exists only when ADC_FILTER_OFFSET_EN is defined.
interface imu_adc_filter_if;
  logic [255:0] adc_channels;
  logic [255:0] filt_channels;
  logic         filt_valid;
  logic [15:0]  frame_count;
`ifdef ADC_FILTER_OFFSET_EN
  logic         cal_strobe;

  modport slave (
    input  adc_channels, cal_strobe,
    output filt_channels, filt_valid, frame_count
  );
  modport master (
    output adc_channels, cal_strobe,
    input  filt_channels, filt_valid, frame_count
  );
`else
  modport slave (
    input  adc_channels,
    output filt_channels, filt_valid, frame_count
  );
  modport master (
    output adc_channels,
    input  filt_channels, filt_valid, frame_count
  );
`endif
endinterface

// File: rtl/imu_adc_filter.sv
// Coherent 8x12-bit ADC sampler + 2^LOG2_AVG decimating averager; output 12 cycles after the final tick, no backpressure.
// Optional offset calibration with ADC_FILTER_OFFSET_EN (adds cal_strobe).
module imu_adc_filter #(
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned LOG2_AVG   = 4
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  imu_adc_filter_if.slave  bus
);

  localparam int unsigned   AW         = 12 + LOG2_AVG;
  localparam int unsigned   NW         = LOG2_AVG + 1;
  localparam logic [15:0]   DIV_LAST   = 16'(SAMPLE_DIV - 1);
  localparam logic [NW-1:0] NSAMP_FULL = NW'(1 << LOG2_AVG);

  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, ACCUM, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic          pending_q, pending_d;
  logic [2:0]    ch_q, ch_d;
  logic [NW-1:0] nsamp_q, nsamp_d;
  logic [11:0]   snap_q [8];
  logic [11:0]   snap_d [8];
  logic [AW-1:0] acc_q [8];
  logic [AW-1:0] acc_d [8];
  logic [255:0]  filt_q, filt_d;
  logic          filt_vld_q, filt_vld_d;
  logic [15:0]   frame_q, frame_d;
  logic [11:0]   adc_lo [8];
  logic [11:0]   avg [8];
  logic          snap_match;
  logic [255:0]  out_word;

  // The bus is asynchronous: a sample is only accepted once two consecutive reads agree.
  always_comb begin
    snap_match = 1'b1;
    for (int k = 0; k < 8; k++) begin
      adc_lo[k] = bus.adc_channels[32*k +: 12];
      avg[k]    = 12'(acc_q[k] >> LOG2_AVG);
      if (adc_lo[k] != snap_q[k]) snap_match = 1'b0;
    end
  end

`ifdef ADC_FILTER_OFFSET_EN
  logic        cal_req_q, cal_req_d;
  logic [11:0] offset_q [8];
  logic [11:0] offset_d [8];
  logic [12:0] diff [8];

  always_comb begin
    cal_req_d = cal_req_q | bus.cal_strobe;
    offset_d  = offset_q;
    out_word  = '0;
    for (int k = 0; k < 8; k++) begin
      diff[k] = {1'b0, avg[k]} - {1'b0, offset_q[k]};
      if (!cal_req_q) out_word[32*k +: 32] = {{19{diff[k][12]}}, diff[k]};
    end
    // The calibrating frame latches its own average as offset and reports zero.
    if (state_q == DONE && cal_req_q) begin
      offset_d  = avg;
      cal_req_d = bus.cal_strobe;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cal_req_q <= 1'b0;
      for (int k = 0; k < 8; k++) offset_q[k] <= '0;
    end else begin
      cal_req_q <= cal_req_d;
      offset_q  <= offset_d;
    end
  end
`else
  always_comb begin
    out_word = '0;
    for (int k = 0; k < 8; k++) out_word[32*k +: 32] = {20'd0, avg[k]};
  end
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = (tick_cnt_q == DIV_LAST);
    tick_cnt_d = tick_d ? 16'd0 : tick_cnt_q + 16'd1;
    pending_d  = pending_q;
    ch_d       = ch_q;
    nsamp_d    = nsamp_q;
    snap_d     = snap_q;
    acc_d      = acc_q;
    filt_d     = filt_q;
    filt_vld_d = 1'b0;
    frame_d    = frame_q;

    if (tick_q && state_q != IDLE) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick_q || pending_q) begin
          state_d   = CAPTURE;
          pending_d = 1'b0;
        end
      end
      CAPTURE: begin
        snap_d  = adc_lo;
        state_d = CHECK;
      end
      CHECK: begin
        if (snap_match) begin
          ch_d    = 3'd0;
          state_d = ACCUM;
        end else begin
          snap_d = adc_lo;
        end
      end
      ACCUM: begin
        acc_d[ch_q] = acc_q[ch_q] + AW'(snap_q[ch_q]);
        ch_d        = ch_q + 3'd1;
        if (ch_q == 3'd7) begin
          nsamp_d = nsamp_q + NW'(1);
          state_d = (nsamp_d == NSAMP_FULL) ? DONE : IDLE;
        end
      end
      DONE: begin
        filt_d     = out_word;
        filt_vld_d = 1'b1;
        frame_d    = frame_q + 16'd1;
        nsamp_d    = '0;
        for (int k = 0; k < 8; k++) acc_d[k] = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
      ch_q       <= '0;
      nsamp_q    <= '0;
      filt_q     <= '0;
      filt_vld_q <= 1'b0;
      frame_q    <= '0;
      for (int k = 0; k < 8; k++) begin
        snap_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      ch_q       <= ch_d;
      nsamp_q    <= nsamp_d;
      filt_q     <= filt_d;
      filt_vld_q <= filt_vld_d;
      frame_q    <= frame_d;
      snap_q     <= snap_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.filt_channels = filt_q;
  assign bus.filt_valid    = filt_vld_q;
  assign bus.frame_count   = frame_q;

endmodule

// File: tb/tb_imu_adc_filter.sv
// Bench for imu_adc_filter: vector table through a scoreboard, plus hand sequences for
// unstable input, reset mid-accumulation, tick overrun and (with ADC_FILTER_OFFSET_EN) calibration.
module tb_imu_adc_filter;
  localparam int unsigned DIV     = 20;
  localparam int unsigned DIV_OVR = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] adc;
  logic         mon_en = 1'b0;
  int           cyc;
  int           n_cmp  = 0;
  int           n_fail = 0;
`ifdef ADC_FILTER_OFFSET_EN
  logic         cal;
`endif

  typedef struct packed {
    logic [255:0] chans;
    logic [15:0]  frame;
    logic [31:0]  edge_n;
  } exp_t;

  typedef struct packed {
    logic [3:0][11:0] s;
    logic [11:0]      d;
    logic [31:0]      exp0;
  } vec_t;

  exp_t sb_q [$];
  exp_t mon_e;
  vec_t vecs [5];

  imu_adc_filter_if bus_m ();
  imu_adc_filter_if bus_o ();

  assign bus_m.adc_channels = adc;
  assign bus_o.adc_channels = adc;
`ifdef ADC_FILTER_OFFSET_EN
  assign bus_m.cal_strobe = cal;
  assign bus_o.cal_strobe = cal;
`endif

  imu_adc_filter #(.SAMPLE_DIV(DIV), .LOG2_AVG(2)) u_dut (
    .sys_clk (clk),
    .reset_n (reset_n),
    .bus     (bus_m)
  );

  imu_adc_filter #(.SAMPLE_DIV(DIV_OVR), .LOG2_AVG(2)) u_ovr (
    .sys_clk (clk),
    .reset_n (reset_n),
    .bus     (bus_o)
  );

  always #5 clk = ~clk;

  // Edge index since the last reset release: edge 1 is the first posedge after release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pack_all(input logic [11:0] v);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = {20'd0, v};
    return r;
  endfunction

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input logic [255:0] c, input int fr, input int e);
    exp_t x;
    x.chans  = c;
    x.frame  = 16'(fr);
    x.edge_n = 32'(e);
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && mon_en && bus_m.filt_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: filt_valid high at edge %0d, required no output", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        for (int k = 0; k < 8; k++)
          check($sformatf("sb_ch%0d", k), bus_m.filt_channels[32*k +: 32], mon_e.chans[32*k +: 32]);
        check("sb_frame", 32'(bus_m.frame_count), 32'(mon_e.frame));
        check("sb_valid_edge", 32'(cyc), mon_e.edge_n);
      end
    end
  end

  initial begin
    logic [255:0] e;
    int n;
    int sum;

    reset_n = 1'b0;
    adc     = '0;
`ifdef ADC_FILTER_OFFSET_EN
    cal     = 1'b0;
`endif
    // samples listed {s3,s2,s1,s0}; channel k sees s[j] + k*d
    vecs[0] = '{s: {12'd1,    12'd1,    12'd1,    12'd1},    d: 12'd100, exp0: 32'd1};
    vecs[1] = '{s: {12'd1,    12'd1,    12'd1,    12'd0},    d: 12'd16,  exp0: 32'd0};
    vecs[2] = '{s: {12'd4095, 12'd4095, 12'd4095, 12'd4095}, d: 12'd0,   exp0: 32'h0000_0FFF};
    vecs[3] = '{s: {12'd41,   12'd30,   12'd20,   12'd10},   d: 12'd7,   exp0: 32'd25};
    vecs[4] = '{s: {12'd4094, 12'd4095, 12'd4095, 12'd4095}, d: 12'd0,   exp0: 32'd4094};

    do_reset();
    check("rst_valid", 32'(bus_m.filt_valid), 32'd0);
    check("rst_frame", 32'(bus_m.frame_count), 32'd0);
    check("rst_ch0", bus_m.filt_channels[31:0], 32'd0);
    check("rst_ch7", bus_m.filt_channels[255:224], 32'd0);
    mon_en = 1'b1;

    // Back-to-back frames; each sample changes mid-interval, well away from its capture edge.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) begin
        n = 4*r + j + 1;
        wait_edge(DIV*(n-1) + 10);
        for (int k = 0; k < 8; k++)
          adc[32*k +: 32] = {20'hABCDE, 12'(int'(vecs[r].s[j]) + k*int'(vecs[r].d))};
      end
      e = '0;
      for (int k = 0; k < 8; k++) begin
        sum = 0;
        for (int j = 0; j < 4; j++) sum += int'(vecs[r].s[j]) + k*int'(vecs[r].d);
        e[32*k +: 32] = (k == 0) ? vecs[r].exp0 : 32'(sum >> 2);
      end
      push(e, r + 1, 4*DIV*(r + 1) + 12);
    end
    drain(200);

    // Unstable bus during the 4th capture: five CHECK retries delay the output by five cycles.
    do_reset();
    adc = pack_all(12'h123);
    push(pack_all(12'h123), 1, 4*DIV + 12 + 5);
    for (int i = 0; i < 4; i++) begin
      wait_edge(4*DIV + 2 + i);
      adc = pack_all((i % 2 == 0) ? 12'hAAA : 12'h555);
    end
    wait_edge(4*DIV + 6);
    adc = pack_all(12'h123);
    drain(100);

    // Reset while accumulating channel 4 of the third sample of frame 2.
    wait_edge(7*DIV + 7);
    reset_n = 1'b0;
    #1;
    check("rstmid_ch0", bus_m.filt_channels[31:0], 32'd0);
    check("rstmid_ch7", bus_m.filt_channels[255:224], 32'd0);
    check("rstmid_frame", 32'(bus_m.frame_count), 32'd0);
    check("rstmid_valid", 32'(bus_m.filt_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push(pack_all(12'h123), 1, 4*DIV + 12);
    drain(150);

    // Tick overrun on the DIV=16 instance: CHECK held for 40 cycles across ticks 32 and 48.
    mon_en = 1'b0;
    do_reset();
    adc = pack_all(12'h777);
    for (int i = 0; i < 40; i++) begin
      wait_edge(DIV_OVR + 2 + i);
      adc = pack_all((i % 2 == 0) ? 12'h0F0 : 12'h30F);
    end
    wait_edge(107);
    check("ovr_frame_pre", 32'(bus_o.frame_count), 32'd0);
    check("ovr_valid_pre", 32'(bus_o.filt_valid), 32'd0);
    wait_edge(108);
    check("ovr_valid", 32'(bus_o.filt_valid), 32'd1);
    check("ovr_frame", 32'(bus_o.frame_count), 32'd1);
    check("ovr_ch0", bus_o.filt_channels[31:0], 32'h0000_030F);
    check("ovr_ch7", bus_o.filt_channels[255:224], 32'h0000_030F);
    wait_edge(109);
    check("ovr_valid_post", 32'(bus_o.filt_valid), 32'd0);
    wait_edge(171);
    check("ovr_frame_hold", 32'(bus_o.frame_count), 32'd1);
    wait_edge(172);
    check("ovr_frame2", 32'(bus_o.frame_count), 32'd2);
    check("ovr_valid2", 32'(bus_o.filt_valid), 32'd1);

`ifdef ADC_FILTER_OFFSET_EN
    do_reset();
    mon_en = 1'b1;
    adc = pack_all(12'd2000);
    cal = 1'b1;
    @(negedge clk);
    cal = 1'b0;
    push('0, 1, 4*DIV + 12);
    wait_edge(4*DIV + 15);
    adc = pack_all(12'd1990);
    push({8{32'hFFFF_FFF6}}, 2, 8*DIV + 12);
    drain(150);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/imu_adc_filter.md
# imu_adc_filter

- Decimating averager placed directly downstream of the IMU ADC wrapper; consumes its flat 8×32-bit `adc_channels` bus.
- The ADC controller updates that bus on `spi_clk`. This block samples it coherently in the `sys_clk` domain at a fixed rate and averages 2^LOG2_AVG samples per channel.
- Presents averaged channels on an identically packed bus, with a one-cycle valid pulse, to the SOPC register slave.

## Interface
- `SAMPLE_DIV`, default 5000: `sys_clk` cycles between sample ticks; legal range 16..65535.
- `LOG2_AVG`, default 4: log2 of samples per average; legal range 0..8.
- `sys_clk`  in  1  system clock, the block's only clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `adc_channels`  in  256  channel k at bits [32k+31:32k]; only [32k+11:32k] are used. Asynchronous to `sys_clk`.
- `filt_channels`  out  256  averaged channels, same packing.
- `filt_valid`  out  1  one-cycle pulse when `filt_channels` has just been updated.
- `frame_count`  out  16  number of completed averages; wraps 65535→0.
- `cal_strobe`  in  1  capture offsets. Present only with `ADC_FILTER_OFFSET_EN`.

## Operation
- **Tick counter:** counts 0..SAMPLE_DIV-1 and wraps. A tick is generated on the wrap.
  - If the FSM is not IDLE when a tick arrives, the tick sets a single `pending` bit.
  - Further ticks while `pending` is set are dropped.
  - IDLE consumes `pending` as a tick.
- **FSM states:** IDLE, CAPTURE, CHECK, ACCUM, DONE.
  - IDLE: on tick/pending → CAPTURE.
  - CAPTURE: `snap` ← `adc_channels` (low 12 bits of each channel) → CHECK.
  - CHECK: compare `adc_channels` against `snap`.
    - Equal: → ACCUM with `ch`=0.
    - Not equal: `snap` ← `adc_channels`, stay in CHECK. Retry is unbounded.
  - ACCUM: one channel per cycle: `acc[ch]` += `snap[ch]`; `ch` increments 0..7.
    - After `ch`=7, increment `nsamp`.
    - If `nsamp` reaches 2^LOG2_AVG → DONE; otherwise → IDLE.
  - DONE: `filt[k]` ← `acc[k] >> LOG2_AVG`, truncating. Then clear all `acc` and `nsamp`, increment `frame_count`, → IDLE.
- **Widths:**
  - `acc` is 12+LOG2_AVG bits and cannot overflow.
  - `nsamp` is LOG2_AVG+1 bits.
  - Output word = {20'd0, avg[11:0]}.
- **LOG2_AVG=0:** every sample passes straight to DONE; output equals the sample.
- **Reset mid-operation:** all state is cleared asynchronously; any partial average is discarded.

## Timing
- **Reset values:** `filt_channels`=0, `filt_valid`=0, `frame_count`=0. Internally: `acc`=0, `nsamp`=0, `pending`=0, tick counter=0, FSM=IDLE.
- **Latency (stable input):**
  - Tick seen in IDLE at edge t.
  - CAPTURE t+1, CHECK t+2, ACCUM t+3..t+10, DONE t+11.
  - `filt_channels`, `filt_valid` and `frame_count` are registered and update together on edge t+12.
  - `filt_valid` is high for exactly one cycle.
- **Each CHECK mismatch** adds one cycle.
- **Busy period** is at most 12 cycles without retries, so SAMPLE_DIV≥16 gives no pending accumulation under a stable input.
- **No backpressure:** the consumer must take data in the `filt_valid` cycle. `filt_channels` holds its value until the next DONE.

## Configuration
- **`ADC_FILTER_OFFSET_EN` defined:**
  - Adds the `cal_strobe` port and 8 offset registers (12 bits each, reset 0).
  - `cal_strobe` sets a sticky `cal_req`.
  - At the next DONE, offset[k] ← that DONE's avg[k] and `cal_req` clears. That DONE outputs 0 for every channel.
  - Output word = sign-extension to 32 bits of the 13-bit signed value (avg[k] − offset[k]).
- **Undefined:** no `cal_strobe` port, no offset logic; outputs are zero-extended as above.

## Test plan
- **Averaging:**
  - Stimulus: LOG2_AVG=2, SAMPLE_DIV=20, channel k held at 100k+1.
  - Required: first `filt_valid` 12 cycles after the 4th tick; channel k reads 100k+1 (ch7=701); `frame_count`=1.
- **Truncation:**
  - Stimulus: LOG2_AVG=2; ch0 samples 0,1,1,1.
  - Required: ch0 output 0.
  - Stimulus: ch0 samples 4095 ×4.
  - Required: ch0 output 4095 (0x00000FFF), upper 20 bits zero.
- **Unstable input:**
  - Stimulus: `adc_channels` toggles every `sys_clk` for 5 cycles after CAPTURE, then holds 0x123 on all channels.
  - Required: CHECK persists 5 cycles; accumulated value is 0x123 only; `filt_valid` is delayed by 5 cycles.
- **Reset during ACCUM:**
  - Stimulus: assert `reset_n`=0 at `ch`=4 of the 3rd sample.
  - Required: outputs are 0 immediately. After release, the next valid needs 4 fresh samples, and a constant input reproduces exactly.
- **Tick overrun:**
  - Stimulus: SAMPLE_DIV=16; hold CHECK with toggling input for 40 cycles.
  - Required: exactly one pending tick is serviced; the other ticks are dropped; `frame_count` counts only the serviced samples.
- **Offset (`ADC_FILTER_OFFSET_EN`):**
  - Stimulus: ch0=2000, pulse `cal_strobe`.
  - Required: the next valid outputs 0.
  - Stimulus: ch0 then set to 1990.
  - Required: a later average reads 0xFFFFFFF6 (−10).
